// File: rtl/sequence_playback.sv
// sequence_playback: plays back a colour sequence on one-hot LEDs.
// Each step lights one LED for ON_CYCLES, then goes dark for OFF_CYCLES.
// Round r plays steps 0..r (r clamped to 32); a one-cycle done pulse ends it.
module sequence_playback #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [32:0][1:0] segment,
    input  logic [5:0]       round,
    input  logic             start,
    output logic [3:0]       leds,
    output logic             busy,
    output logic             done,
    output logic [5:0]       step
);

    localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    leds_q, leds_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [5:0]    step_q, step_d;
    logic [5:0]    round_q, round_d;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    // State and registered outputs; reset aborts playback at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            leds_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= 6'd0;
            round_q <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            leds_q  <= leds_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            step_q  <= step_d;
            round_q <= round_d;
        end
    end

    // Next state and next outputs; counter clears on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        leds_d  = leds_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step_d  = step_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_ON;
                    round_d = (round > 6'd32) ? 6'd32 : round;
                    step_d  = 6'd0;
                    leds_d  = onehot(segment[0]);
                    busy_d  = 1'b1;
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                    leds_d  = 4'b0000;
                end
            end
            S_OFF: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d = '0;
                    if (step_q < round_q) begin
                        state_d = S_ON;
                        step_d  = step_q + 6'd1;
                        leds_d  = onehot(segment[step_q + 6'd1]);
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                leds_d  = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign leds = leds_q;
    assign busy = busy_q;
    assign done = done_q;
    assign step = step_q;

endmodule

// File: tb/tb_sequence_playback.sv
// Bench for sequence_playback: a per-cycle expected-output schedule model
// plus directed scenarios with hand-computed timing, and randomized plays.
module tb_sequence_playback;

    localparam int ON  = 3;
    localparam int OFF = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       round = 6'd0;
    logic [32:0][1:0] segment = '0;
    logic [3:0]       leds;
    logic             busy;
    logic             done;
    logic [5:0]       step;

    sequence_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk(clk), .reset(reset), .segment(segment), .round(round),
        .start(start), .leds(leds), .busy(busy), .done(done), .step(step)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] leds;
        logic       busy;
        logic       done;
        logic [5:0] step;
    } exp_t;

    exp_t q[$];
    exp_t cur = '0;
    int   vectors = 0;
    int   errors  = 0;

    // Model: when idle and start is seen, lay out the whole playback as a
    // list of expected per-cycle outputs, then consume one entry per clock.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            cur = '0;
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (!cur.busy && start) begin
            int   rr;
            exp_t e;
            rr = (round > 6'd32) ? 32 : int'(round);
            for (int s = 0; s <= rr; s++) begin
                for (int k = 0; k < ON; k++) begin
                    e.leds = 4'b0001 << segment[s];
                    e.busy = 1'b1; e.done = 1'b0; e.step = 6'(s);
                    q.push_back(e);
                end
                for (int k = 0; k < OFF; k++) begin
                    e.leds = 4'b0000;
                    e.busy = 1'b1; e.done = 1'b0; e.step = 6'(s);
                    q.push_back(e);
                end
            end
            e.leds = 4'b0000; e.busy = 1'b1; e.done = 1'b1; e.step = 6'(rr);
            q.push_back(e);
            cur = q.pop_front();
        end else begin
            cur.leds = 4'b0000;
            cur.busy = 1'b0;
            cur.done = 1'b0;
        end
    end

    // Every-cycle compare against the model, plus the one-hot property.
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if ({leds, busy, done, step} !== cur || $countones(leds) > 1) begin
                errors++;
                $display("FAIL cycle t=%0t: got leds=%b busy=%b done=%b step=%0d, expected leds=%b busy=%b done=%b step=%0d",
                         $time, leds, busy, done, step, cur.leds, cur.busy, cur.done, cur.step);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start one playback and observe it from the first ON cycle to idle.
    // diff = cycles from first ON cycle to done; -1 if done never seen.
    task automatic play(input logic [5:0] r, input int pulse_step,
                        input int chg_step, input logic [5:0] newr,
                        output int diff, output int maxstep,
                        output int busy_n, output logic [3:0] first_leds);
        bit pulsed;
        pulsed = 0;
        diff = -1; maxstep = 0; busy_n = 0;
        @(negedge clk);
        round = r;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_leds = leds;
        for (int k = 0; k < 2000; k++) begin
            if (busy) busy_n++;
            if (int'(step) > maxstep) maxstep = int'(step);
            if (done) diff = k;
            if (!busy) break;
            if (pulse_step >= 0 && int'(step) == pulse_step && !pulsed) begin
                start = 1'b1;
                pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (chg_step >= 0 && int'(step) == chg_step) round = newr;
            @(negedge clk);
        end
        start = 1'b0;
        chk("play_terminates", int'(busy), 0);
    endtask

    initial begin
        int d, ms, bn, rr, bound;
        logic [3:0] fl;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_leds", int'(leds), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_step", int'(step), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Scenario 1: single red-ish step, colour 2 -> leds[2].
        segment[0] = 2'b10;
        play(6'd0, -1, -1, 6'd0, d, ms, bn, fl);
        chk("s1_first_leds", int'(fl), 4);
        chk("s1_done_delay", d, 5);
        chk("s1_busy_cycles", bn, 6);
        chk("s1_max_step", ms, 0);

        // Scenario 2: four steps, all colours.
        segment[0] = 2'b00; segment[1] = 2'b01; segment[2] = 2'b10; segment[3] = 2'b11;
        play(6'd3, -1, -1, 6'd0, d, ms, bn, fl);
        chk("s2_first_leds", int'(fl), 1);
        chk("s2_done_delay", d, 20);
        chk("s2_max_step", ms, 3);
        chk("s2_busy_cycles", bn, 21);

        // Scenario 3: round 40 clamps to 33 steps.
        play(6'd40, -1, -1, 6'd0, d, ms, bn, fl);
        chk("s3_done_delay", d, 165);
        chk("s3_max_step", ms, 32);

        // Scenario 4: start pulsed during step 1 is ignored.
        play(6'd3, 1, -1, 6'd0, d, ms, bn, fl);
        chk("s4_done_delay", d, 20);
        chk("s4_max_step", ms, 3);

        // Scenario 6: round changed 1 -> 5 mid-playback has no effect.
        play(6'd1, -1, 0, 6'd5, d, ms, bn, fl);
        chk("s6_max_step", ms, 1);
        chk("s6_done_delay", d, 10);

        // Scenario 5: asynchronous reset during OFF of step 2.
        @(negedge clk);
        round = 6'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bound = 0;
        while (!(step == 6'd2 && leds == 4'b0000 && busy) && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        chk("s5_reached_off2", int'(bound < 200), 1);
        #2 reset = 1'b1;
        #1;
        chk("s5_async_leds", int'(leds), 0);
        chk("s5_async_busy", int'(busy), 0);
        chk("s5_async_step", int'(step), 0);
        chk("s5_async_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("s5_idle_after", int'(busy), 0);
        segment[0] = 2'b01;
        play(6'd0, -1, -1, 6'd0, d, ms, bn, fl);
        chk("s5_replay_leds", int'(fl), 2);
        chk("s5_replay_delay", d, 5);

        // start held high: restart right after the one idle cycle.
        @(negedge clk);
        round = 6'd1;
        start = 1'b1;
        bound = 0;
        while (!done && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        chk("held_done_seen", int'(done), 1);
        @(negedge clk);
        chk("held_idle_gap", int'(busy), 0);
        @(negedge clk);
        chk("held_restart", int'(busy), 1);
        start = 1'b0;
        bound = 0;
        while (busy && bound < 200) begin
            @(negedge clk);
            bound++;
        end
        chk("held_finish", int'(busy), 0);

        // Randomized plays, checked by the model and by closed-form timing.
        for (int it = 0; it < 15; it++) begin
            for (int i = 0; i < 33; i++) segment[i] = 2'($urandom_range(0, 3));
            rr = $urandom_range(0, 40);
            play(6'(rr), ($urandom_range(0, 1) == 1) ? 0 : -1,
                 ($urandom_range(0, 1) == 1) ? 0 : -1, 6'($urandom_range(0, 63)),
                 d, ms, bn, fl);
            if (rr > 32) rr = 32;
            chk("rand_done_delay", d, (rr + 1) * (ON + OFF));
            chk("rand_max_step", ms, rr);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
